// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: key codes, debounce state encoding and key-map lookup for the keypad front end
// Optional feature macro: KEYPAD_MULTI_REJECT_EN (see keypad_scanner).
package keypad_scanner_pkg;
  localparam logic [4:0] KEY_0    = 5'd0;
  localparam logic [4:0] KEY_1    = 5'd1;
  localparam logic [4:0] KEY_2    = 5'd2;
  localparam logic [4:0] KEY_3    = 5'd3;
  localparam logic [4:0] KEY_4    = 5'd4;
  localparam logic [4:0] KEY_5    = 5'd5;
  localparam logic [4:0] KEY_6    = 5'd6;
  localparam logic [4:0] KEY_7    = 5'd7;
  localparam logic [4:0] KEY_8    = 5'd8;
  localparam logic [4:0] KEY_9    = 5'd9;
  localparam logic [4:0] KEY_A    = 5'd10;
  localparam logic [4:0] KEY_B    = 5'd11;
  localparam logic [4:0] KEY_C    = 5'd12;
  localparam logic [4:0] KEY_D    = 5'd13;
  localparam logic [4:0] KEY_STAR = 5'd14;
  localparam logic [4:0] KEY_HASH = 5'd15;
  localparam logic [4:0] KEY_NONE = 5'h1F;
  typedef enum logic {DB_IDLE = 1'b0, DB_COMPARE = 1'b1} db_state_t;
  // Entry {r,c} holds the code for row r, column c; listed from r3c3 down to r0c0.
  localparam logic [79:0] KEY_TABLE = {KEY_D, KEY_HASH, KEY_0, KEY_STAR,
                                       KEY_C, KEY_9, KEY_8, KEY_7,
                                       KEY_B, KEY_6, KEY_5, KEY_4,
                                       KEY_A, KEY_3, KEY_2, KEY_1};
  function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return KEY_TABLE[5*int'({r, c}) +: 5];
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-code debouncer with key hold and one-cycle new-press strobe
// Ports: clk, rst (sync, active-low), frame_valid (one cycle per frame end), frame_code[4:0],
//        key[4:0] (debounced code), key_strobe (one cycle after key takes a new non-KEY_NONE value).
module keypad_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_valid,
  input  logic [4:0] frame_code,
  output logic [4:0] key,
  output logic       key_strobe
);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  db_state_t state, state_n;
  logic [4:0] fc, cand, key_d;
  logic [CW-1:0] cnt, cnt_inc;
  assign cnt_inc = cnt == CW'(DEBOUNCE_CNT) ? cnt : cnt + 1'b1;
  always_comb begin
    state_n = DB_IDLE;
    if (state == DB_IDLE && frame_valid) state_n = DB_COMPARE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= DB_IDLE;
      fc         <= KEY_NONE;
      cand       <= KEY_NONE;
      cnt        <= '0;
      key        <= KEY_NONE;
      key_d      <= KEY_NONE;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_n;
      key_d      <= key;
      key_strobe <= key != key_d && key != KEY_NONE;
      if (state == DB_IDLE && frame_valid) fc <= frame_code;
      if (state == DB_COMPARE) begin
        if (fc == cand) begin
          cnt <= cnt_inc;
          if (cnt_inc == CW'(DEBOUNCE_CNT) && cand != key) key <= cand;
        end else begin
          cand <= fc;
          cnt  <= CW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner, decoder and debounced key output
// Ports: clk, rst (sync, active-low), row[3:0] (async active-low returns), col[3:0] (active-low drive),
//        key[4:0] (debounced code, KEY_NONE when idle), key_strobe (one cycle per new press).
// Build option: define KEYPAD_MULTI_REJECT_EN to turn any frame with two or more low samples into KEY_NONE.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] key,
  output logic       key_strobe
);
  localparam int DW = $clog2(SCAN_DIV);
  logic [3:0] row_m, row_s, low;
  logic [DW-1:0] div;
  logic [1:0] c, r;
  logic found, last, frame_end, hit;
  logic [4:0] code, hit_code, frame_code;
  assign low       = ~row_s;
  assign last      = div == DW'(SCAN_DIV - 1);
  assign frame_end = last && c == 2'd3;
  assign hit       = |low;
  assign r         = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
  assign hit_code  = key_code(r, c);
  assign col       = ~(4'b0001 << c);
`ifdef KEYPAD_MULTI_REJECT_EN
  logic multi, many;
  // Two lows in this column, or a low here after an earlier hit, marks the frame as a multi-press.
  assign many       = multi || (found && hit) || (low & (low - 4'd1)) != 4'd0;
  assign frame_code = many ? KEY_NONE : found ? code : hit ? hit_code : KEY_NONE;
  always_ff @(posedge clk) begin
    if (!rst || frame_end) multi <= 1'b0;
    else if (last) multi <= many;
  end
`else
  assign frame_code = found ? code : hit ? hit_code : KEY_NONE;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
      div   <= '0;
      c     <= '0;
      found <= 1'b0;
      code  <= KEY_NONE;
    end else begin
      row_m <= row;
      row_s <= row_m;
      div   <= last ? '0 : div + 1'b1;
      if (last) c <= c + 2'd1;
      if (frame_end) begin
        found <= 1'b0;
        code  <= KEY_NONE;
      end else if (last && hit && !found) begin
        found <= 1'b1;
        code  <= hit_code;
      end
    end
  end
  keypad_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_valid(frame_end),
    .frame_code (frame_code),
    .key        (key),
    .key_strobe (key_strobe)
  );
endmodule
